// File: rtl/hash_scheduler.sv
// hash_scheduler: grants multi-beat hash jobs to a bank of SHA-2 cores round-robin and
//   returns the finished digests in the order the jobs were accepted.
// Latency: one IDLE cycle to grant a job; beat path and digest path are combinational (0 cycles).
// Backpressure: s_axis_tready follows the granted core's core_tready; a digest is held at the
//   head (dig_tready low) until m_axis_tready; non-head digests wait until their core is at the head.
//
// Ports:
//   axi_aclk, reset                 clock, synchronous active-high reset
//   s_axis_*                        job beats in; tuser = SHA type, sampled on the first beat only
//   core_en / core_sha_type         per-core enable and SHA type, held for the whole job
//   core_tdata / core_tvalid        broadcast beat data, one-hot valid to the granted core
//   core_tready                     per-core beat ready
//   dig_tdata / dig_tvalid          per-core digest in (core i in slice i)
//   dig_tready                      one-hot digest accept to the core at the head of the order FIFO
//   m_axis_*                        digest out; tkeep marks the digest bytes for the SHA type
module hash_scheduler #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_CORES  = 4
) (
    input  logic                            axi_aclk,
    input  logic                            reset,

    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [1:0]                      s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,

    output logic [NUM_CORES-1:0]            core_en,
    output logic [2*NUM_CORES-1:0]          core_sha_type,
    output logic [DATA_WIDTH-1:0]           core_tdata,
    output logic [NUM_CORES-1:0]            core_tvalid,
    input  logic [NUM_CORES-1:0]            core_tready,

    input  logic [NUM_CORES*DATA_WIDTH-1:0] dig_tdata,
    input  logic [NUM_CORES-1:0]            dig_tvalid,
    output logic [NUM_CORES-1:0]            dig_tready,

    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready
);

    localparam int IDX_W  = $clog2(NUM_CORES);
    localparam int CNT_W  = $clog2(NUM_CORES + 1);
    localparam int KEEP_W = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     rr;
    logic [NUM_CORES-1:0] busy;
    logic [1:0]           sha_type_q [NUM_CORES];

    // Dispatch-order FIFO: core indices in acceptance order.
    logic [IDX_W-1:0]     ord_mem [NUM_CORES];
    logic [IDX_W-1:0]     ord_rd_ptr;
    logic [IDX_W-1:0]     ord_wr_ptr;
    logic [CNT_W-1:0]     ord_count;
    logic [IDX_W-1:0]     head;
    logic                 ord_nonempty;

    // ------------------------------------------------------------------
    // Round-robin grant: first free core scanning upward from rr with wrap.
    // Scanning from the far end down lets the closest free core win without
    // a found flag.
    // ------------------------------------------------------------------
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand = rr + IDX_W'(k);
            if (!busy[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    logic grant_fire;
    logic beat_fire;
    logic out_fire;

    assign grant_fire = (state == IDLE) && s_axis_tvalid && grant_found;
    assign beat_fire  = (state == STREAM) && s_axis_tvalid && core_tready[sel];
    assign out_fire   = m_axis_tvalid && m_axis_tready;

    // ------------------------------------------------------------------
    // Input FSM, per-core busy/type registers and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            rr    <= '0;
            busy  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                sha_type_q[i] <= 2'b00;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        sel                   <= grant_idx;
                        sha_type_q[grant_idx] <= s_axis_tuser;
                        state                 <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_fire && s_axis_tlast) begin
                        rr    <= sel + IDX_W'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // The granted core is free and the released core is busy, so these
            // two updates never touch the same bit.
            if (grant_fire) begin
                busy[grant_idx] <= 1'b1;
            end
            if (out_fire) begin
                busy[head] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Order FIFO. Depth equals NUM_CORES (a power of two), so the pointers
    // wrap naturally. Each entry corresponds to exactly one busy core, so it
    // cannot overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            ord_rd_ptr <= '0;
            ord_wr_ptr <= '0;
            ord_count  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                ord_mem[i] <= '0;
            end
        end else begin
            if (grant_fire) begin
                ord_mem[ord_wr_ptr] <= grant_idx;
                ord_wr_ptr          <= ord_wr_ptr + IDX_W'(1);
            end
            if (out_fire) begin
                ord_rd_ptr <= ord_rd_ptr + IDX_W'(1);
            end
            case ({grant_fire, out_fire})
                2'b10:   ord_count <= ord_count + CNT_W'(1);
                2'b01:   ord_count <= ord_count - CNT_W'(1);
                default: ord_count <= ord_count;
            endcase
        end
    end

    assign head         = ord_mem[ord_rd_ptr];
    assign ord_nonempty = (ord_count != '0);

    // ------------------------------------------------------------------
    // Core-facing outputs
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] sel_oh;
    logic [NUM_CORES-1:0] head_oh;

    assign sel_oh  = NUM_CORES'(1) << sel;
    assign head_oh = NUM_CORES'(1) << head;

    assign core_en       = busy;
    assign core_tdata    = s_axis_tdata;
    assign core_tvalid   = ((state == STREAM) && s_axis_tvalid) ? sel_oh : '0;
    assign s_axis_tready = (state == STREAM) && core_tready[sel];

    logic [DATA_WIDTH-1:0] dig_slice [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        assign core_sha_type[2*i +: 2] = sha_type_q[i];
        assign dig_slice[i]            = dig_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // ------------------------------------------------------------------
    // Output path: everything is taken from the FIFO head in the same cycle.
    // ------------------------------------------------------------------
    function automatic logic [KEEP_W-1:0] keep_pattern(input logic [1:0] t);
        logic [KEEP_W-1:0] k;
        k = '0;
        case (t)
            2'b00:   k[27:0] = '1;   // SHA224: 28 bytes
            2'b01:   k[31:0] = '1;   // SHA256: 32 bytes
            2'b10:   k[47:0] = '1;   // SHA384: 48 bytes
            default: k       = '1;   // SHA512: 64 bytes
        endcase
        return k;
    endfunction

    assign m_axis_tvalid = ord_nonempty && dig_tvalid[head];
    assign m_axis_tdata  = dig_slice[head];
    assign m_axis_tkeep  = keep_pattern(sha_type_q[head]);
    assign m_axis_tlast  = m_axis_tvalid;
    assign dig_tready    = (ord_nonempty && m_axis_tready) ? head_oh : '0;

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_count_matches_busy: assert property (@(posedge axi_aclk) disable iff (reset)
        int'(ord_count) == $countones(busy));
    a_core_tvalid_onehot: assert property (@(posedge axi_aclk) disable iff (reset)
        $onehot0(core_tvalid));
    a_dig_tready_onehot: assert property (@(posedge axi_aclk) disable iff (reset)
        $onehot0(dig_tready));

endmodule
